// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed, checksummed byte stream and
// writes 32-bit instruction words into memory while holding the processor in reset.
module prog_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              proc_hold,
   output logic              done,
   output logic              error
);

   localparam int          DEPTH   = 2 ** ADDR_W;
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CHK,
      DONE,
      ERR
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [ADDR_W-1:0]   widx_q, widx_d;
   logic [1:0]          bidx_q, bidx_d;
   logic [23:0]         asm_q, asm_d;
   logic [7:0]          csum_q, csum_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                accept;
   logic [15:0]         len_new;
   logic                len_ok;
   logic                last_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         widx_q      <= '0;
         bidx_q      <= '0;
         asm_q       <= '0;
         csum_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         widx_q      <= widx_d;
         bidx_q      <= bidx_d;
         asm_q       <= asm_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      widx_d      = widx_q;
      bidx_d      = bidx_q;
      asm_d       = asm_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      in_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                  (state_q == DATA)   || (state_q == CHK);
      accept    = in_valid && in_ready;
      len_new   = {len_q[15:8], in_data};
      len_ok    = (len_new != 16'd0) && ({1'b0, len_new} <= DEPTH_L);
      // Word count never exceeds DEPTH, so N-1 always fits in the address width.
      last_word = (widx_q == ADDR_W'(len_q - 16'd1));

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LEN_HI;
               widx_d  = '0;
               bidx_d  = '0;
               csum_d  = '0;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d[15:8] = in_data;
               state_d     = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d[7:0] = in_data;
               state_d    = len_ok ? DATA : ERR;
            end
         end
         DATA: begin
            if (accept) begin
               asm_d  = {asm_q[15:0], in_data};
               csum_d = csum_q ^ in_data;
               bidx_d = bidx_q + 2'd1;
               // Fourth byte completes the word; the write is presented next cycle.
               if (bidx_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = widx_q;
                  mem_wdata_d = {asm_q, in_data};
                  widx_d      = widx_q + 1'b1;
                  if (last_word) begin
                     state_d = CHK;
                  end
               end
            end
         end
         CHK: begin
            if (accept) begin
               state_d = (in_data == csum_q) ? DONE : ERR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign done      = (state_q == DONE);
   assign error     = (state_q == ERR);
   assign proc_hold = (state_q != DONE);

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the instruction-memory address width; depth DEPTH = 2**ADDR_W words.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a program load.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_data  input  8  upstream byte.
REQ-007 in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready.
REQ-008 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 mem_addr  output  ADDR_W  word address of the write.
REQ-010 mem_wdata  output  32  instruction word to write.
REQ-011 proc_hold  output  1  keeps the downstream pipelined processor halted with PC=0 while high.
REQ-012 done  output  1  load completed and checksum matched.
REQ-013 error  output  1  load aborted: bad length or checksum mismatch.

Function
REQ-014 Stream format SHALL be: count N (16 bits, high byte first), then 4N instruction bytes (each word most-significant byte first), then one checksum byte.
REQ-015 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
REQ-016 start in IDLE, DONE or ERR SHALL move to LEN_HI next cycle, clear done/error, clear word index, byte index and running checksum; start in any other state SHALL be ignored.
REQ-017 in_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA, CHK; bytes offered in other states SHALL NOT be consumed.
REQ-018 LEN_HI SHALL capture N[15:8]; LEN_LO SHALL capture N[7:0] and go to DATA if 1 <= N <= DEPTH, else ERR.
REQ-019 In DATA each accepted byte SHALL shift into a 32-bit assembly register and XOR into an 8-bit running checksum; a 2-bit byte index SHALL wrap 3->0.
REQ-020 On acceptance of the 4th byte of a word, the next cycle SHALL show mem_we=1, mem_addr=word index, mem_wdata=assembled word; mem_we SHALL be 0 in all other cycles.
REQ-021 Word index SHALL increment after each word; when word N is accepted the FSM SHALL go to CHK.
REQ-022 CHK SHALL compare the accepted byte to the running checksum: equal -> DONE, different -> ERR.
REQ-023 Back-to-back bytes (in_valid held high) SHALL be accepted one per cycle with no bubbles, including across word boundaries and state transitions LEN_LO->DATA and DATA->CHK.
REQ-024 in_valid low in any receiving state SHALL stall with all state held.
REQ-025 DONE: done=1, proc_hold=0, in_ready=0; held until start or rst.
REQ-026 ERR: error=1, proc_hold=1, in_ready=0; held until start or rst; words already written are not erased.
REQ-027 proc_hold SHALL be 1 in every state except DONE.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, proc_hold=1, done=0, error=0, all counters and checksum to 0.
REQ-029 rst asserted mid-load SHALL abort immediately; any pending mem_we SHALL NOT appear; a fresh start is required afterwards.

Verification
REQ-030 start; bytes 00 02 28 01 00 0A 28 02 00 14 1D back-to-back -> mem_we at addr 0 data 2801000A, addr 1 data 28020014; done=1, proc_hold=0, error=0.
REQ-031 Same stream with checksum 1C -> both words written, error=1, done=0, proc_hold=1.
REQ-032 start; count 00 00 -> ERR immediately after LEN_LO byte, no mem_we; count 04 01 with ADDR_W=10 -> ERR.
REQ-033 Same as REQ-030 with in_valid toggling 1/0 every cycle -> identical memory writes and done; no byte dropped or duplicated.
REQ-034 rst pulsed after 6 data bytes -> all outputs at reset values, no further mem_we; then start and REQ-030 stream -> correct load.
REQ-035 start asserted during DATA -> ignored, load completes normally; start in DONE -> done drops, proc_hold rises, new load accepted.
